if_fetch_queue: RTL
===================

# if_fetch_queue

Parametrised multi-word instruction fetch stage with a decoupling instruction queue. It sits between instruction memory/ICACHE and ID. Each IM access returns FETCH_W consecutive instructions, which are buffered in a QDEPTH-entry FIFO. ID receives one instruction per cycle through a valid/stall handshake. Branch redirects flush the queue and restart fetch at the alternate PC.

## Interface
- FETCH_W, 2: instructions per IM access; legal values 1, 2, 4.
- QDEPTH, 8: queue entries; power of two, at least 2*FETCH_W.
- RESET_PC, 32'hBFC00000: fetch address after reset.

- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- Instr_address_2IM  out  32  address of the first word of the fetch group.
- Instr_fIM  in  32*FETCH_W  fetch group; word i (bits 32i+31:32i) is at address + 4i.
- IM_Ready  in  1  Instr_fIM is valid for the presented address this cycle.
- Stall_fmem  in  1  data-memory stall; freezes the whole block.
- Request_Alt_PC  in  1  redirect request.
- Alt_PC  in  32  redirect target, word aligned.
- STALL  in  1  ID cannot accept an instruction this cycle.
- Instr_Valid  out  1  queue head is valid.
- Instr1_OUT  out  32  queue head instruction.
- Instr_PC_OUT  out  32  queue head PC.
- Instr_PC_Plus4  out  32  Instr_PC_OUT + 4.
- Q_Count  out  $clog2(QDEPTH)+1  queue occupancy.

## Operation
- **State:** fetch_pc register, plus a circular queue of {instr, pc} entries with head/tail pointers and a count. Pointers wrap modulo QDEPTH.
- **Address select:** Instr_address_2IM = Request_Alt_PC ? Alt_PC : fetch_pc (combinational).
- **Pop:** occurs when Instr_Valid && !STALL && !Stall_fmem. Exactly one entry is removed per pop.
- **Push:** occurs when IM_Ready && !Stall_fmem && (QDEPTH - count_before_pop) >= FETCH_W, or the redirect case below applies.
  - A push writes FETCH_W entries in address order.
  - fetch_pc <= Instr_address_2IM + 4*FETCH_W, modulo 2^32.
- **No push:** fetch_pc holds. When only Request_Alt_PC is honored, fetch_pc <= Alt_PC.
- **Redirect** (Request_Alt_PC && !Stall_fmem):
  - All queue entries are discarded, including the head.
  - If IM_Ready, the Alt_PC group is pushed into the now-empty queue in the same edge.
  - A pop in the same cycle is still counted as accepted by ID.
  - The requester asserts redirect only after the delay-slot instruction has been accepted.
- **Stall_fmem:** blocks push, pop and redirect. The requester holds Request_Alt_PC until Stall_fmem drops.
- **STALL:** blocks pop only. Fetch continues until the queue has fewer than FETCH_W free slots.
- **Free-space check:** uses occupancy before the same-cycle pop, which is conservative. Simultaneous push and pop are legal.
- **When !Instr_Valid:** Instr1_OUT, Instr_PC_OUT and Instr_PC_Plus4 are driven 0.
- **$display on each edge:** emits the fetch address, a push/redirect/stall indication, and Q_Count.

## Timing
- **Reset (asynchronous, immediate):**
  - Queue is emptied, Q_Count=0, Instr_Valid=0.
  - Head outputs are 0.
  - fetch_pc=RESET_PC, so Instr_address_2IM=RESET_PC.
- **Fetch latency:** a group accepted at edge N appears on the head outputs after edge N, when the queue was empty before it. Otherwise it appears behind the older entries.
- **Redirect latency:** the Alt_PC instruction is on Instr1_OUT after the redirect edge when IM_Ready was high in that cycle. Otherwise it appears one cycle after the first IM_Ready.
- **Queue outputs:** all combinational from the head entry and Q_Count. There is no bypass from Instr_fIM to the outputs.
- **Peak throughput:** one instruction per cycle to ID; FETCH_W instructions per cycle into the queue.
- **Reset mid-operation:** all queued entries are lost. Fetch restarts at RESET_PC after RESET deasserts.

## Test plan
Defaults for all scenarios: FETCH_W=2, QDEPTH=8.

- **Reset and steady state.** Assert reset, then release with IM_Ready=1 and STALL=0.
  - Required: address BFC00000 at the first edge, then BFC00008.
  - After the first edge: Instr_PC_OUT=BFC00000, Instr_Valid=1.
  - The next head is BFC00004, and heads increase by 4 each cycle.
  - Q_Count rises 2, 3, 4 … until pushes block at 7, then settles between 6 and 7.
- **Backpressure.** STALL=1 throughout from reset.
  - Required: four pushes fill Q_Count to 8.
  - Instr_address_2IM then holds BFC00020 with no further push.
  - The head stays BFC00000.
- **Redirect.** With 5 entries queued, pulse Request_Alt_PC with Alt_PC=BFC00100, IM_Ready=1, STALL=0.
  - Required after the edge: Q_Count=2, Instr_PC_OUT=BFC00100, Instr_address_2IM=BFC00108.
- **Memory stall.** Stall_fmem=1 for 3 cycles with IM_Ready=1, STALL=0, and a redirect pulse inside the window.
  - Required: Q_Count, the head and fetch_pc are unchanged.
  - The redirect is ignored.
- **Wrap-around.** Redirect to FFFFFFF8.
  - Required: the group holds FFFFFFF8 and FFFFFFFC, and fetch_pc becomes 00000000.
  - Run 3 full fill/drain cycles: PC order is preserved across pointer wrap.
- **Asynchronous reset mid-operation.** Assert RESET between clock edges with Q_Count=6.
  - Required: Q_Count=0, Instr_Valid=0 and Instr_address_2IM=BFC00000 immediately, before the next edge.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Multi-word instruction fetch stage: each IM access returns FETCH_W words that
// are buffered in a QDEPTH-entry circular queue and handed to ID one per cycle.
module if_fetch_queue #(
  parameter int unsigned FETCH_W  = 2,
  parameter int unsigned QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic                    CLK,
  input  logic                    RESET,
  output logic [31:0]             Instr_address_2IM,
  input  logic [32*FETCH_W-1:0]   Instr_fIM,
  input  logic                    IM_Ready,
  input  logic                    Stall_fmem,
  input  logic                    Request_Alt_PC,
  input  logic [31:0]             Alt_PC,
  input  logic                    STALL,
  output logic                    Instr_Valid,
  output logic [31:0]             Instr1_OUT,
  output logic [31:0]             Instr_PC_OUT,
  output logic [31:0]             Instr_PC_Plus4,
  output logic [$clog2(QDEPTH):0] Q_Count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] GROUP      = CW'(FETCH_W);
  localparam logic [PW-1:0] GROUP_PTR  = PW'(FETCH_W);
  localparam logic [31:0]   GROUP_BYTES = 32'(4 * FETCH_W);

  logic [31:0]   fetch_pc;
  logic [31:0]   instr_q [QDEPTH];
  logic [31:0]   pc_q    [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          run;
  logic          redirect;
  logic          pop;
  logic          push;
  logic          space_ok;
  logic [CW-1:0] free_slots;
  logic [PW-1:0] wr_base;
  logic [31:0]   next_fetch_pc;

  assign Instr_address_2IM = Request_Alt_PC ? Alt_PC : fetch_pc;

  // A memory stall freezes everything, including an incoming redirect.
  assign run         = !Stall_fmem;
  assign redirect    = Request_Alt_PC && run;
  assign Instr_Valid = (count != '0);
  assign pop         = Instr_Valid && !STALL && run;

  // Free space is judged before the same-cycle pop, so a full queue never
  // depends on ID accepting an instruction to make room.
  assign free_slots    = CW'(QDEPTH) - count;
  assign space_ok      = free_slots >= GROUP;
  assign push          = IM_Ready && run && (redirect || space_ok);
  assign wr_base       = redirect ? '0 : tail;
  assign next_fetch_pc = Instr_address_2IM + GROUP_BYTES;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of its peers regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      // The flushed queue restarts at slot 0; a ready Alt_PC group lands there.
      head     <= '0;
      tail     <= push ? GROUP_PTR : '0;
      count    <= push ? GROUP : '0;
      fetch_pc <= push ? next_fetch_pc : Alt_PC;
    end else begin
      if (pop) head <= head + PW'(1);
      if (push) begin
        tail     <= tail + GROUP_PTR;
        fetch_pc <= next_fetch_pc;
      end
      count <= count + (push ? GROUP : '0) - (pop ? CW'(1) : '0);
    end
  end

  // NOTE: queue storage has no reset; entry validity is tracked only by
  // count, which lets the array map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      for (int i = 0; i < int'(FETCH_W); i++) begin
        instr_q[wr_base + PW'(i)] <= Instr_fIM[32*i +: 32];
        pc_q[wr_base + PW'(i)]    <= Instr_address_2IM + 32'(4 * i);
      end
    end
  end

  assign Instr1_OUT     = Instr_Valid ? instr_q[head] : '0;
  assign Instr_PC_OUT   = Instr_Valid ? pc_q[head] : '0;
  assign Instr_PC_Plus4 = Instr_Valid ? pc_q[head] + 32'd4 : '0;
  assign Q_Count        = count;

endmodule
